// File: rtl/config_pkg.sv
// config_pkg: shared fixed-point and vector types for the ternary matmul datapath.
package config_pkg;
  localparam int D = 4;
  localparam int FixedPointPrecision = 16;
  typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0] vector_t;
  typedef logic [$clog2(D)-1:0] vec_idx_t;
endpackage

// File: rtl/ternary_vector_stream_io_unpacker.sv
// vector_unpacker: captures a result vector and replays it as a serial element stream.
module vector_unpacker
  import config_pkg::*;
#(
  parameter int N = D,
  parameter int W = FixedPointPrecision,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0][W-1:0] vec_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [W-1:0]        elem_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o
);
  typedef enum logic {IDLE, DRAIN} ul_state_t;
  ul_state_t st_q, st_d;
  logic [IW-1:0] out_idx;
  logic [N-1:0][W-1:0] result;
  logic out_fire, at_last;
  assign ready_o = st_q == IDLE;
  assign valid_o = st_q == DRAIN;
  assign at_last = out_idx == IW'(N-1);
  assign elem_o = result[out_idx];
  assign last_o = valid_o && at_last;
  assign out_fire = valid_o && ready_i;
  always_comb
    st_d = st_q == IDLE ? (valid_i ? DRAIN : IDLE) : (out_fire && at_last ? IDLE : DRAIN);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      out_idx <= '0;
      result <= '0;
    end else begin
      st_q <= st_d;
      if (ready_o && valid_i) result <= vec_i;
      if (out_fire) out_idx <= at_last ? '0 : out_idx + 1'b1;
    end
  end
endmodule

// File: rtl/ternary_vector_stream_io.sv
// ternary_vector_stream_io: serial<->vector adapter around ternary_matmul; TVSIO_LAST_CHECK_EN enables s_last_i framing check.
module ternary_vector_stream_io
  import config_pkg::*;
#(
  parameter int N = D,
  localparam int ELEM_W = FixedPointPrecision,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ELEM_W-1:0]        s_elem_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic                     s_last_i,
  output logic [N-1:0][ELEM_W-1:0] mm_vector_o,
  output logic                     mm_valid_o,
  input  logic                     mm_ready_i,
  input  logic [N-1:0][ELEM_W-1:0] mm_vector_i,
  input  logic                     mm_valid_i,
  output logic                     mm_ready_o,
  output logic [ELEM_W-1:0]        m_elem_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_last_o,
  output logic                     err_o
);
  typedef enum logic [1:0] {FILL, PRESENT, HOLD} ld_state_t;
  ld_state_t ld_q, ld_d;
  logic [IW-1:0] in_idx;
  logic [N-1:0][ELEM_W-1:0] operand;
  logic in_fire, in_last, cap;
  assign s_ready_o = ld_q == FILL;
  assign mm_valid_o = ld_q == PRESENT;
  assign mm_vector_o = operand;
  assign in_fire = s_valid_i && s_ready_o;
  assign in_last = in_idx == IW'(N-1);
  assign cap = mm_valid_i && mm_ready_o;
  // Operand stays frozen through HOLD: the matmul reads it element by element while working.
  always_comb
    ld_d = ld_q == FILL ? (in_fire && in_last ? PRESENT : FILL) :
           ld_q == PRESENT ? (mm_ready_i ? HOLD : PRESENT) :
           (cap ? FILL : HOLD);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_q <= FILL;
      in_idx <= '0;
      operand <= '0;
    end else begin
      ld_q <= ld_d;
      if (in_fire) begin
        operand[in_idx] <= s_elem_i;
        in_idx <= in_last ? '0 : in_idx + 1'b1;
      end
    end
  end
`ifdef TVSIO_LAST_CHECK_EN
  logic err_q;
  assign err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (in_fire && (s_last_i != in_last)) err_q <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign err_o = 1'b0;
`endif
  vector_unpacker #(.N(N), .W(ELEM_W)) u_unpacker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .vec_i   (mm_vector_i),
    .valid_i (mm_valid_i),
    .ready_o (mm_ready_o),
    .elem_o  (m_elem_o),
    .valid_o (m_valid_o),
    .ready_i (m_ready_i),
    .last_o  (m_last_o)
  );
endmodule

// File: tb/tb_ternary_vector_stream_io.sv
// tb_ternary_vector_stream_io: directed bench for ternary_vector_stream_io with D=4, 16-bit elements.
module tb_ternary_vector_stream_io;
  logic clk_i = 0, rst_i = 0;
  logic [15:0] s_elem_i = '0;
  logic s_valid_i = 0, s_ready_o, s_last_i = 0;
  logic [3:0][15:0] mm_vector_o, mm_vector_i = '0;
  logic mm_valid_o, mm_ready_i = 0, mm_valid_i = 0, mm_ready_o;
  logic [15:0] m_elem_o;
  logic m_valid_o, m_ready_i = 0, m_last_o, err_o;
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  ternary_vector_stream_io dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_elem_i(s_elem_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_i(s_last_i),
    .mm_vector_o(mm_vector_o), .mm_valid_o(mm_valid_o), .mm_ready_i(mm_ready_i),
    .mm_vector_i(mm_vector_i), .mm_valid_i(mm_valid_i), .mm_ready_o(mm_ready_o),
    .m_elem_o(m_elem_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .err_o(err_o)
  );

  task automatic stream4(input logic [15:0] a, b, c, d, input int last_at);
    logic [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      s_elem_i = v[i];
      s_valid_i = 1;
      s_last_i = (i == last_at);
      @(negedge clk_i);
    end
    s_valid_i = 0;
    s_last_i = 0;
  endtask

  task automatic test_reset;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready_o); end
    checks++; if (mm_ready_o !== 1'b1) begin errors++; $display("FAIL reset_mm_ready got %b want 1", mm_ready_o); end
    checks++; if (mm_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mm_valid got %b want 0", mm_valid_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid_o); end
    checks++; if (m_last_o !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    checks++; if (mm_vector_o !== 64'd0) begin errors++; $display("FAIL reset_vector got %h want 0", mm_vector_o); end
  endtask

  task automatic test_load;
    logic [3:0][15:0] ev;
    ev = {16'd4, 16'd3, 16'd2, 16'd1};
    stream4(16'd1, 16'd2, 16'd3, 16'd4, 3);
    checks++; if (mm_valid_o !== 1'b1) begin errors++; $display("FAIL load_mm_valid got %b want 1", mm_valid_o); end
    checks++; if (mm_vector_o !== ev) begin errors++; $display("FAIL load_vector got %h want %h", mm_vector_o, ev); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL present_s_ready got %b want 0", s_ready_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL good_framing_err got %b want 0", err_o); end
    mm_ready_i = 1;
    @(negedge clk_i);
    mm_ready_i = 0;
    s_elem_i = 16'd99;
    s_valid_i = 1;
    repeat (2) @(negedge clk_i);
    s_valid_i = 0;
    checks++; if (mm_valid_o !== 1'b0) begin errors++; $display("FAIL hold_mm_valid got %b want 0", mm_valid_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL hold_s_ready got %b want 0", s_ready_o); end
    checks++; if (mm_vector_o !== ev) begin errors++; $display("FAIL hold_vector got %h want %h", mm_vector_o, ev); end
  endtask

  task automatic test_drain;
    logic [15:0] ee [4];
    ee = '{16'd10, -16'sd20, 16'd30, -16'sd40};
    mm_vector_i = {-16'sd40, 16'd30, -16'sd20, 16'd10};
    mm_valid_i = 1;
    m_ready_i = 1;
    checks++; if (mm_ready_o !== 1'b1) begin errors++; $display("FAIL idle_mm_ready got %b want 1", mm_ready_o); end
    @(negedge clk_i);
    mm_valid_i = 0;
    mm_vector_i = '0;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL capture_refill got %b want 1", s_ready_o); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        m_ready_i = 0;
        repeat (3) begin
          checks++; if (m_elem_o !== ee[1] || m_valid_o !== 1'b1) begin errors++; $display("FAIL stall_elem got %h/%b want %h/1", m_elem_o, m_valid_o, ee[1]); end
          @(negedge clk_i);
        end
        m_ready_i = 1;
      end
      checks++; if (m_valid_o !== 1'b1 || m_elem_o !== ee[i]) begin errors++; $display("FAIL drain_elem%0d got %h/%b want %h/1", i, m_elem_o, m_valid_o, ee[i]); end
      checks++; if (m_last_o !== (i == 3)) begin errors++; $display("FAIL drain_last%0d got %b want %b", i, m_last_o, i == 3); end
      checks++; if (mm_ready_o !== 1'b0) begin errors++; $display("FAIL drain_mm_ready%0d got %b want 0", i, mm_ready_o); end
      @(negedge clk_i);
    end
    checks++; if (m_valid_o !== 1'b0 || mm_ready_o !== 1'b1) begin errors++; $display("FAIL drain_done got %b/%b want 0/1", m_valid_o, mm_ready_o); end
  endtask

  task automatic test_overlap;
    logic [3:0][15:0] ev;
    logic [15:0] r1 [4];
    logic [15:0] r2 [4];
    ev = {16'd8, 16'd7, 16'd6, 16'd5};
    r1 = '{16'd100, 16'd200, 16'd300, 16'd400};
    r2 = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
    m_ready_i = 0;
    mm_vector_i = {16'd400, 16'd300, 16'd200, 16'd100};
    mm_valid_i = 1;
    @(negedge clk_i);
    mm_valid_i = 0;
    stream4(16'd5, 16'd6, 16'd7, 16'd8, 3);
    checks++; if (mm_valid_o !== 1'b1 || mm_vector_o !== ev) begin errors++; $display("FAIL overlap_present got %b/%h want 1/%h", mm_valid_o, mm_vector_o, ev); end
    mm_ready_i = 1;
    @(negedge clk_i);
    mm_ready_i = 0;
    mm_vector_i = {-16'sd4, -16'sd3, -16'sd2, -16'sd1};
    mm_valid_i = 1;
    repeat (2) @(negedge clk_i);
    checks++; if (mm_ready_o !== 1'b0) begin errors++; $display("FAIL overlap_backpressure got %b want 0", mm_ready_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL overlap_hold got %b want 0", s_ready_o); end
    m_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid_o !== 1'b1 || m_elem_o !== r1[i]) begin errors++; $display("FAIL overlap_r1_%0d got %h/%b want %h/1", i, m_elem_o, m_valid_o, r1[i]); end
      @(negedge clk_i);
    end
    checks++; if (mm_ready_o !== 1'b1 || s_ready_o !== 1'b0) begin errors++; $display("FAIL overlap_pre_capture got %b/%b want 1/0", mm_ready_o, s_ready_o); end
    @(negedge clk_i);
    mm_valid_i = 0;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL overlap_refill got %b want 1", s_ready_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid_o !== 1'b1 || m_elem_o !== r2[i] || m_last_o !== (i == 3)) begin errors++; $display("FAIL overlap_r2_%0d got %h/%b/%b want %h/1/%b", i, m_elem_o, m_valid_o, m_last_o, r2[i], i == 3); end
      @(negedge clk_i);
    end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL overlap_end got %b want 0", m_valid_o); end
  endtask

  task automatic test_reset_mid;
    logic [3:0][15:0] ev;
    ev = {16'd24, 16'd23, 16'd22, 16'd21};
    s_valid_i = 1;
    s_elem_i = 16'd11;
    @(negedge clk_i);
    s_elem_i = 16'd12;
    @(negedge clk_i);
    s_valid_i = 0;
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    checks++; if (mm_valid_o !== 1'b0 || s_ready_o !== 1'b1 || mm_vector_o !== 64'd0) begin errors++; $display("FAIL midreset got %b/%b/%h want 0/1/0", mm_valid_o, s_ready_o, mm_vector_o); end
    stream4(16'd21, 16'd22, 16'd23, 16'd24, 3);
    checks++; if (mm_valid_o !== 1'b1 || mm_vector_o !== ev) begin errors++; $display("FAIL midreset_reload got %b/%h want 1/%h", mm_valid_o, mm_vector_o, ev); end
  endtask

  task automatic test_last_check;
    logic [3:0][15:0] ev;
    ev = {16'd34, 16'd33, 16'd32, 16'd31};
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    stream4(16'd31, 16'd32, 16'd33, 16'd34, 1);
`ifdef TVSIO_LAST_CHECK_EN
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL framing_err got %b want 1", err_o); end
`else
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL framing_err got %b want 0", err_o); end
`endif
    checks++; if (mm_valid_o !== 1'b1 || mm_vector_o !== ev) begin errors++; $display("FAIL framing_vector got %b/%h want 1/%h", mm_valid_o, mm_vector_o, ev); end
    repeat (3) @(negedge clk_i);
`ifdef TVSIO_LAST_CHECK_EN
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL framing_sticky got %b want 1", err_o); end
`endif
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL framing_clear got %b want 0", err_o); end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset;
    test_load;
    test_drain;
    test_overlap;
    test_reset_mid;
    test_last_check;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
